// File: rtl/qseq_pkg.sv
// Shared definitions for the queue command sequencer: the queue's 2-bit op
// encoding (cmd[17:16]), FSM state encoding, default timeout and a small
// saturating-increment helper used by the optional statistics counters.
package qseq_pkg;

  // Op encoding, identical to the downstream queue controller's cmd[17:16].
  localparam logic [1:0] OP_PUSH     = 2'b00;
  localparam logic [1:0] OP_POP      = 2'b01;
  localparam logic [1:0] OP_PUSHPREV = 2'b10;
  localparam logic [1:0] OP_NOP      = 2'b11;

  // Cycles allowed in S_ACK + S_DONE before a command is aborted.
  localparam int DEFAULT_TIMEOUT = 64;

  localparam int STAT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ACK   = 3'd2,
    S_DONE  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/queue_cmd_seq.sv
// Command sequencer in front of the 32-entry queue controller. Accepts one
// host command at a time, issues it to the queue with a go strobe, waits for
// the queue to drop and re-raise ready, and returns one response per command
// (pop data, error, timeout). A command stuck in the queue for TIMEOUT cycles
// is abandoned with a timeout response.
//
// Optional build macro QSEQ_STATS_EN adds saturating 16-bit counters
// stat_cmds / stat_errors / stat_timeouts.
module queue_cmd_seq
  import qseq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int TO_W    = 7                 // 2**TO_W must exceed TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,        // asynchronous, active low
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                q_go,
  output logic [DATA_W+1:0]   q_cmd,
  input  logic                q_ready,
  input  logic                q_error,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_error,
  output logic                rsp_timeout
`ifdef QSEQ_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_cmds,
  output logic [STAT_W-1:0]   stat_errors,
  output logic [STAT_W-1:0]   stat_timeouts
`endif
);

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [TO_W-1:0]   to_cnt;

  // The last wait cycle before the counter would reach TIMEOUT.
  logic to_expire;
  assign to_expire = (to_cnt == TO_W'(TIMEOUT - 1));

  assign cmd_ready = (state == S_IDLE);

  // Queue-side strobe and command exist only while issuing.
  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches.
    q_go  = 1'b0;
    q_cmd = '0;
    if (state == S_ISSUE) begin
      q_go  = q_ready;
      q_cmd = {op_q, data_q};
    end
  end

  // Sequencer FSM with registered response fields and inline timeout counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      data_q      <= '0;
      to_cnt      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
            if (cmd_op == OP_NOP) begin
              state       <= S_RESP;
              rsp_valid   <= 1'b1;
              rsp_data    <= '0;
              rsp_error   <= 1'b0;
              rsp_timeout <= 1'b0;
            end else begin
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          // Waiting for the queue to become ready is not timed.
          if (q_ready) begin
            state  <= S_ACK;
            to_cnt <= '0;
          end
        end

        S_ACK, S_DONE: begin
          if (state == S_DONE && q_ready) begin
            state       <= S_RESP;
            rsp_valid   <= 1'b1;
            rsp_error   <= q_error;
            rsp_timeout <= 1'b0;
            rsp_data    <= (op_q == OP_POP && !q_error) ? mem_rdata : '0;
          end else if (to_expire) begin
            to_cnt      <= to_cnt + 1'b1;
            state       <= S_RESP;
            rsp_valid   <= 1'b1;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (state == S_ACK && !q_ready) state <= S_DONE;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef QSEQ_STATS_EN
  // Every entry to S_RESP is preceded by at least one cycle with rsp_valid
  // low, so a rising edge of rsp_valid marks exactly one response.
  logic rsp_valid_d;
  logic rsp_new;
  assign rsp_new = rsp_valid && !rsp_valid_d;

  // Saturating response statistics, updated the cycle after S_RESP entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_d   <= 1'b0;
      stat_cmds     <= '0;
      stat_errors   <= '0;
      stat_timeouts <= '0;
    end else begin
      rsp_valid_d <= rsp_valid;
      if (rsp_new) begin
        if (!rsp_timeout) stat_cmds     <= sat_inc(stat_cmds);
        if (rsp_error)    stat_errors   <= sat_inc(stat_errors);
        if (rsp_timeout)  stat_timeouts <= sat_inc(stat_timeouts);
      end
    end
  end
`endif

endmodule

// File: doc/queue_cmd_seq.md
Name: queue_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the 32-entry queue controller.
- Accepts host commands over a valid/ready handshake and issues each one to the queue through its go/cmd/ready interface.
- Waits for the queue to complete the operation, then returns one response per command: popped data, error flag and timeout flag.
- Supports one command in flight only. The queue's own PUSH/POP/PUSHPREV/IDLE op encoding is reused unchanged.

Parameters:
- DATA_W, 16, width of the push/pop data word.
- TIMEOUT, 64, cycles allowed in the wait states before the command is aborted with a timeout.
- TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  2  00 PUSH, 01 POP, 10 PUSHPREV, 11 NOP.
- cmd_data  in  DATA_W  push data; ignored for other ops.
- q_go  out  1  go strobe to the queue.
- q_cmd  out  DATA_W+2  {op, data} to the queue.
- q_ready  in  1  queue idle/ready.
- q_error  in  1  queue error flag.
- mem_rdata  in  DATA_W  queue memory read data (the queue's r_num source).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts the response.
- rsp_data  out  DATA_W  popped word for POP; 0 for all other ops.
- rsp_error  out  1  the queue flagged an error.
- rsp_timeout  out  1  the queue did not complete within TIMEOUT cycles.

Behaviour:
- Reset (reset=0, async):
  - State goes to S_IDLE.
  - rsp_valid, rsp_data, rsp_error, rsp_timeout = 0.
  - Op/data holding registers and the timeout counter = 0.
  - cmd_ready=1 and q_go=0 follow from S_IDLE.
  - Reset asserted mid-operation abandons the command with no response.
- States:
  - S_IDLE: cmd_ready=1. On cmd_valid, latch op and data.
    - op=NOP goes directly to S_RESP with error=0 and no go issued.
    - Any other op goes to S_ISSUE.
  - S_ISSUE: q_go = q_ready (combinational); q_cmd = {op, data} is driven throughout the state. If q_ready=1, go to S_ACK and clear the timeout counter; otherwise stay in S_ISSUE (no timeout counted here).
  - S_ACK: wait for q_ready=0, then go to S_DONE.
  - S_DONE: wait for q_ready=1. On that cycle:
    - capture rsp_error = q_error;
    - capture rsp_data = mem_rdata if op=POP and q_error=0, else 0;
    - go to S_RESP.
  - S_RESP: rsp_valid=1 and all rsp_* fields held stable. Return to S_IDLE on rsp_ready.
- Latency: a command accepted at edge k produces q_go during cycle k+1 if q_ready=1.
  - The queue drops ready at k+2 and raises it again at k+5.
  - rsp_valid therefore asserts at k+6 for a 5-cycle queue round trip.
  - NOP: rsp_valid asserts at k+1.
- Timeout:
  - The counter increments every cycle in S_ACK and S_DONE.
  - If it reaches TIMEOUT, go to S_RESP with rsp_timeout=1, rsp_error=1 and rsp_data=0.
  - After a timeout the sequencer returns to S_IDLE normally; no queue recovery is attempted.
- Outputs outside S_ISSUE: q_go=0 and q_cmd=0.
- cmd_ready is 0 in every state except S_IDLE, so no command is accepted while a response is pending.
- rsp_valid may be held indefinitely; the response is not dropped.
- mem_rdata must be valid by the cycle q_ready returns high, i.e. memory read latency ≤1 cycle after r_en.

Optional Feature:
- Macro QSEQ_STATS_EN.
- When defined, adds outputs stat_cmds, stat_errors and stat_timeouts, each 16 bits and saturating.
  - Each counter increments on entry to S_RESP for completed commands (including NOP), error responses and timeouts respectively.
  - All three clear on reset.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package qseq_pkg holds:
  - op localparams OP_PUSH, OP_POP, OP_PUSHPREV, OP_NOP, matching the queue's 2-bit cmd[17:16] encoding;
  - state encodings;
  - the default TIMEOUT value.
- No sub-module is required. The timeout counter is inline.

Test Plan:
- PUSH 0x1234 against a model queue → q_go for exactly one cycle with q_cmd=0x01234; rsp_valid with error=0, data=0.
- PUSH 0xAAAA, then POP → second response carries data=0xAAAA, error=0.
- POP on an empty queue (model q_error=1) → rsp_error=1, rsp_data=0.
- q_ready held 0 at issue for 10 cycles → q_go stays low until q_ready=1, then the command completes normally.
- Model never raises q_ready after go → at TIMEOUT=64 cycles: rsp_timeout=1, rsp_error=1; next command accepted afterwards.
- NOP with rsp_ready=0 for 5 cycles → rsp_valid held stable, cmd_ready=0 throughout; reset pulsed in S_DONE → all outputs at reset values, cmd_ready=1.
